fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side controller for the layer buffering FIFO; drains it in fixed-length bursts toward the next compute stage.
- Presents the burst length to the FIFO (its M_count input) and waits for the FIFO's registered "enough data" flag.
- Issues read enables and absorbs the FIFO read latency in a small skid buffer.
- Re-emits the data as a valid/ready stream with a per-burst last flag, and raises done after a programmed number of bursts.

Parameters:
- WIDTH, 128, data word width; matches the FIFO.
- ADDR_BITS, 10, FIFO address bits; count fields are ADDR_BITS+1 wide.
- RD_LAT, 1, cycles from fifo_rd_en to valid fifo_dout.
- SKID_DEPTH, 4, output skid buffer entries; must be a power of two and at least RD_LAT+2.
- NUM_W, 16, width of the burst-count field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches burst_len and burst_num
- burst_len  in  ADDR_BITS+1  words per burst
- burst_num  in  NUM_W  bursts per job
- fifo_count  out  ADDR_BITS+1  latched burst_len, driven to the FIFO's M_count
- fifo_ready  in  1  FIFO M_Ready (registered; one cycle stale)
- fifo_rd_en  out  1  FIFO read enable
- fifo_dout  in  WIDTH  FIFO read data
- m_valid  out  1  output word valid
- m_data  out  WIDTH  output word
- m_last  out  1  last word of the current burst
- m_ready  in  1  downstream accept
- busy  out  1  job active
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset values: fifo_rd_en=0, m_valid=0, m_last=0, busy=0, done=0, fifo_count=0, m_data=0. Skid buffer empties, in-flight pipe clears, state=IDLE.
- Reset mid-job aborts immediately with no done pulse. The FIFO is reset by its owner, not by this block.
- States:
  - IDLE: on start with burst_len≠0 and burst_num≠0, latch both values, set busy=1, go to WAIT.
  - IDLE, degenerate start: start with burst_len=0 or burst_num=0 pulses done in the next cycle, with no reads and busy staying 0.
  - start while busy=1 is ignored.
  - WAIT: when fifo_ready=1, go to READ with word_cnt=0.
  - READ: assert fifo_rd_en when occ+inflight<SKID_DEPTH. occ is the skid buffer occupancy; inflight is the number of reads still inside the RD_LAT pipe. Each rd_en increments word_cnt. On the rd_en with word_cnt=burst_len-1, go to GAP.
  - GAP: hold 2 cycles, because fifo_ready lags the FIFO count. Then, if bursts_issued<burst_num, go to WAIT; otherwise go to FLUSH.
  - FLUSH: when the skid buffer and the in-flight pipe are empty and the final word has been handshaked, pulse done, clear busy, go to IDLE.
- fifo_rd_en is never asserted outside READ and never more than burst_len times per burst.
- Read latency: a valid-tag shift register of depth RD_LAT carries each rd_en, together with an is-last bit (the word_cnt=burst_len-1 read). When a tag emerges, fifo_dout and the tag are pushed into the skid buffer in that same cycle.
- Output:
  - m_valid = occ≠0. m_data and m_last come from the skid buffer head.
  - Pop on m_valid&&m_ready. m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - Push and pop in the same cycle leave occ unchanged.
- Credit rule: the occ+inflight check guarantees the buffer never overflows, so no data-loss path exists.
- Throughput: with m_ready held at 1, READ issues one read per cycle, and the first m_valid appears RD_LAT+1 cycles after the first rd_en.
- done timing: done asserts in the cycle after the handshake of the final m_last of the final burst.
- Widths: word_cnt is ADDR_BITS+1 bits and bursts_issued is NUM_W bits; neither can wrap because both are compared against latched values.
- fifo_count is held for the whole job and returns to 0 in IDLE.

Decomposition:
- Shared package cnn_fifo_pkg holds:
  - the state enum (IDLE, WAIT, READ, GAP, FLUSH)
  - GAP_CYCLES=2
  - the default FIFO read latency constant
  - FIFO_DEPTH=1024, shared with the write side
- One sub-module: skid_fifo, a register-based FIFO of WIDTH+1 bits × SKID_DEPTH. It has push, pop and occupancy outputs and zero-latency head visibility.

Test Plan:
- Basic burst: burst_len=8, burst_num=1, FIFO preloaded with 8 words 0..7, m_ready=1. Expect exactly 8 rd_en, outputs 0..7, m_last only on word 7, done one cycle after that handshake, busy low afterwards.
- Data starvation: burst_len=16, burst_num=3, writer supplies 16 words every 50 cycles. Expect no rd_en before fifo_ready, a GAP of ≥2 cycles between bursts, 48 words in order, and m_last on words 15, 31 and 47.
- Backpressure: m_ready toggles 1/0 every cycle, and is held at 0 for 20 cycles mid-burst. Expect occ never above 4, fifo_rd_en stalling, no lost or duplicated words, and m_data stable while stalled.
- Boundaries: start with burst_len=0 gives done next cycle and no rd_en. burst_len=1024 with a full FIFO gives 1024 words. start during busy is ignored, with burst_len unchanged.
- Reset mid-job: rst asserted in READ after 5 reads. All outputs return to reset values the next cycle, there is no done pulse, and a new start runs normally.

Source files
------------

// File: rtl/cnn_fifo_pkg.sv
// cnn_fifo_pkg: shared types and constants for the layer buffering FIFO read and write sides
package cnn_fifo_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, READ, GAP, FLUSH} state_t;
  localparam int GAP_CYCLES = 2;
  localparam int FIFO_RD_LAT = 1;
  localparam int FIFO_DEPTH = 1024;
endpackage

// File: rtl/fifo_burst_reader_skid_fifo.sv
// skid_fifo: small register FIFO whose head word is visible in the same cycle it is written
module skid_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      occ
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  // storage, pointers and occupancy; push and pop together leave occ unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains the layer FIFO in fixed-length bursts into a valid/ready stream
module fifo_burst_reader
  import cnn_fifo_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int ADDR_BITS = 10,
  parameter int RD_LAT = FIFO_RD_LAT,
  parameter int SKID_DEPTH = 4,
  parameter int NUM_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_BITS:0] burst_len,
  input  logic [NUM_W-1:0]   burst_num,
  output logic [ADDR_BITS:0] fifo_count,
  input  logic               fifo_ready,
  output logic               fifo_rd_en,
  input  logic [WIDTH-1:0]   fifo_dout,
  output logic               m_valid,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_last,
  input  logic               m_ready,
  output logic               busy,
  output logic               done
);
  localparam int OW = $clog2(SKID_DEPTH) + 1;
  localparam int CW = $clog2(SKID_DEPTH + RD_LAT + 1) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t state;
  logic [ADDR_BITS:0] word_cnt;
  logic [NUM_W-1:0] num_q, bursts_issued, bursts_done;
  logic [GW-1:0] gap_cnt;
  logic [RD_LAT-1:0] vld, lst;
  logic [OW-1:0] occ;
  logic [CW-1:0] inflight;
  logic [WIDTH:0] head;
  logic rd_last, pop, fin;
  // reads still travelling through the FIFO read latency
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld[i]);
  end
  assign fifo_rd_en = state == READ && CW'(occ) + inflight < CW'(SKID_DEPTH);
  assign rd_last = word_cnt == fifo_count - 1'b1;
  assign m_valid = occ != '0;
  assign {m_last, m_data} = head;
  assign pop = m_valid && m_ready;
  assign fin = pop && m_last && bursts_done == num_q - 1'b1;
  // valid/last tags shadow each read until its data appears on fifo_dout
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
    end else begin
      vld[0] <= fifo_rd_en;
      lst[0] <= rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end
  skid_fifo #(.WIDTH(WIDTH + 1), .DEPTH(SKID_DEPTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .push(vld[RD_LAT-1]),
    .din ({lst[RD_LAT-1], fifo_dout}),
    .pop (pop),
    .dout(head),
    .occ (occ)
  );
  // job sequencing; the final last handshake ends the job from whichever state it lands in
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fifo_count <= '0;
      num_q <= '0;
      word_cnt <= '0;
      bursts_issued <= '0;
      bursts_done <= '0;
      gap_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop && m_last) bursts_done <= bursts_done + 1'b1;
      case (state)
        IDLE: if (start) begin
          if (burst_len != '0 && burst_num != '0) begin
            fifo_count <= burst_len;
            num_q <= burst_num;
            bursts_issued <= '0;
            bursts_done <= '0;
            busy <= 1'b1;
            state <= WAIT;
          end else done <= 1'b1;
        end
        WAIT: if (fifo_ready) begin
          word_cnt <= '0;
          state <= READ;
        end
        READ: if (fifo_rd_en) begin
          word_cnt <= word_cnt + 1'b1;
          if (rd_last) begin
            bursts_issued <= bursts_issued + 1'b1;
            gap_cnt <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= bursts_issued < num_q ? WAIT : FLUSH;
        end
        default: ;
      endcase
      if (fin) begin
        done <= 1'b1;
        busy <= 1'b0;
        fifo_count <= '0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: scoreboard bench with a behavioural FIFO model feeding the reader
module tb_fifo_burst_reader;
  logic clk = 0, rst = 1, start = 0, fifo_ready = 0, m_ready = 1;
  logic [10:0] burst_len = 0, fifo_count;
  logic [15:0] burst_num = 0;
  logic fifo_rd_en, m_valid, m_last, busy, done;
  logic [127:0] fifo_dout = 0, m_data;
  int checks = 0, passed = 0, cyc = 0, underflow = 0;
  int rd_cnt = 0, acc_cnt = 0, last_hs_cyc = -10;
  logic [127:0] fq[$];
  logic [128:0] exp_q[$];
  logic stall_prev = 0;
  logic [129:0] stall_val;

  fifo_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .burst_num(burst_num),
    .fifo_count(fifo_count), .fifo_ready(fifo_ready), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    fifo_ready <= fifo_count != 0 && fq.size() >= int'(fifo_count);
    if (fifo_rd_en) begin
      if (fq.size() == 0) underflow <= underflow + 1;
      else fifo_dout <= fq.pop_front();
    end
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      acc_cnt = rd_cnt;
      stall_prev = 0;
    end else begin
      logic [128:0] e;
      if (fifo_rd_en) rd_cnt++;
      if (m_valid && m_ready) acc_cnt++;
      if (busy) chk("skid_bound", (rd_cnt - acc_cnt) <= 4, 1);
      if (stall_prev) chk("stall_hold", {m_valid, m_last, m_data}, stall_val);
      stall_prev = m_valid && !m_ready;
      stall_val = {m_valid, m_last, m_data};
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", {m_last, m_data}, 160'hdead);
        else begin
          e = exp_q.pop_front();
          chk("word", {m_last, m_data}, e);
          if (m_last) last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int n, input int base);
    for (int i = 0; i < n; i++) fq.push_back(128'(base + i));
  endtask

  task automatic expect_job(input int len, input int num, input int base);
    for (int i = 0; i < len * num; i++) exp_q.push_back({(i % len) == len - 1, 128'(base + i)});
  endtask

  task automatic pulse_start(input int len, input int num);
    burst_len = 11'(len);
    burst_num = 16'(num);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_rd_en"}, fifo_rd_en, 0);
    chk({nm, "_m_valid"}, m_valid, 0);
    chk({nm, "_m_last"}, m_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_fifo_count"}, fifo_count, 0);
    chk({nm, "_m_data"}, m_data, 0);
  endtask

  task automatic wait_done(input int len, input int num, input int rd0, input int budget);
    bit got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("done_timing", cyc, last_hs_cyc + 1);
      chk("rd_count", rd_cnt - rd0, len * num);
      chk("words_drained", exp_q.size(), 0);
    end
    tick();
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("count_after", fifo_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by time limit, got %0d checks want finish", checks);
    $fatal(1);
  end

  initial begin
    int rd0, seen;
    repeat (3) tick();
    @(negedge clk);
    check_idle("reset");
    tick();
    rst = 0;
    tick();
    rd0 = rd_cnt;
    pulse_start(0, 1);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    tick();
    pulse_start(4, 0);
    @(negedge clk);
    chk("num0_done", done, 1);
    chk("num0_busy", busy, 0);
    chk("degen_no_reads", rd_cnt - rd0, 0);
    tick();
    preload(8, 0);
    expect_job(8, 1, 0);
    rd0 = rd_cnt;
    pulse_start(8, 1);
    wait_done(8, 1, rd0, 200);
    tick();
    expect_job(16, 3, 100);
    rd0 = rd_cnt;
    pulse_start(16, 3);
    fork
      wait_done(16, 3, rd0, 400);
      begin
        for (int b = 0; b < 3; b++) begin
          preload(16, 100 + 16 * b);
          if (b == 0) begin
            repeat (5) tick();
            burst_len = 3;
            burst_num = 1;
            start = 1;
            tick();
            start = 0;
            @(negedge clk);
            chk("busy_start_ignored", fifo_count, 16);
            repeat (40) tick();
            chk("burst0_reads", rd_cnt - rd0, 16);
            repeat (3) tick();
          end else repeat (50) tick();
        end
      end
    join
    tick();
    preload(32, 200);
    expect_job(32, 1, 200);
    rd0 = rd_cnt;
    pulse_start(32, 1);
    fork
      wait_done(32, 1, rd0, 400);
      begin
        repeat (12) begin
          m_ready = ~m_ready;
          tick();
        end
        m_ready = 0;
        repeat (20) tick();
        repeat (100) begin
          m_ready = ~m_ready;
          tick();
        end
        m_ready = 1;
      end
    join
    tick();
    preload(1024, 1000);
    expect_job(1024, 1, 1000);
    rd0 = rd_cnt;
    pulse_start(1024, 1);
    wait_done(1024, 1, rd0, 2000);
    tick();
    preload(8, 3000);
    expect_job(8, 1, 3000);
    rd0 = rd_cnt;
    pulse_start(8, 1);
    for (int k = 0; k < 50 && rd_cnt - rd0 < 5; k++) @(negedge clk);
    chk("reached_5_reads", rd_cnt - rd0 >= 5, 1);
    @(posedge clk);
    #1;
    rst = 1;
    tick();
    fq.delete();
    exp_q.delete();
    @(negedge clk);
    check_idle("midreset");
    tick();
    rst = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | int'(done);
    end
    chk("no_done_after_abort", seen, 0);
    tick();
    preload(8, 4000);
    expect_job(4, 2, 4000);
    rd0 = rd_cnt;
    pulse_start(4, 2);
    wait_done(4, 2, rd0, 300);
    chk("no_underflow", underflow, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
